add_seq_ctrl: RTL and testbench
===============================

// Module: add_seq_ctrl
// PURPOSE
//   Sequencer for multi-precision add/subtract on a single shared 4-bit adder slice.
//   Operands are captured on start and processed LSB-first, one 4-bit slice per clock.
//   A registered carry is chained between slices, then the result is presented with a done pulse.
//   Wide arithmetic reuses one small ripple slice instead of a full-width adder.
// PARAMETERS
//   W  16  operand/result width; must be a multiple of 4 (NSLICE = W/4, derived localparam)
// PORTS
//   clk    in   1  system clock, rising-edge active
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request; sampled only in IDLE or DONE
//   sub    in   1  0: s = a + b + ci; 1: s = a + ~b + 1 (ci ignored)
//   a      in   W  operand A, sampled on accepted start
//   b      in   W  operand B, sampled on accepted start
//   ci     in   1  carry-in for add mode, sampled on accepted start
//   busy   out  1  high while slices are being processed (RUN)
//   done   out  1  one-cycle pulse, result valid
//   s      out  W  result, held until the next completion
//   co     out  1  carry out of bit W-1 (sub mode: 1 = no borrow)
//   ovf    out  1  two's-complement signed overflow
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, s=0, co=0, ovf=0; slice index and carry cleared.
//   Reset mid-RUN aborts the operation; no done pulse; the result is discarded.
//   FSM states: IDLE, RUN, DONE.
//     IDLE -start-> RUN. Capture a, b_eff = sub ? ~b : b, carry = sub ? 1 : ci, idx = 0.
//     RUN: on every edge add slice idx (a[4i+3:4i] + b_eff[4i+3:4i] + carry).
//       Write the 4-bit sum into result bits [4i+3:4i] and the slice carry-out into carry.
//       idx <= idx+1. After slice NSLICE-1, go to DONE.
//     DONE: done=1 for exactly this cycle. Next edge: start=1 -> RUN (new capture), else IDLE.
//   start is ignored in RUN; operand inputs may change freely after capture.
//   busy=1 exactly in RUN (NSLICE cycles). done and busy are never high together.
//   Latency: start accepted at edge E0 -> done high in the cycle after edge E0+NSLICE.
//     Back-to-back throughput is one result per NSLICE+1 cycles.
//   s/co/ovf update only at the edge entering DONE; they hold their value through IDLE and the next RUN.
//   ovf = (a[W-1] == b_eff[W-1]) && (s[W-1] != a[W-1]), using captured values.
//   All arithmetic is modulo 2^W; co is the only carry beyond bit W-1.
//   Slice idx counter width: clog2(NSLICE), minimum 1 bit; it never exceeds NSLICE-1.
// TESTING (W=16, NSLICE=4)
//   add 0x1234 + 0x4321, ci=0 -> busy for 4 cycles, then done pulse; s=0x5555, co=0, ovf=0.
//   add 0xFFFF + 0x0001, ci=0 -> s=0x0000, co=1, ovf=0 (carry ripples through all 4 slices).
//   add 0x7FFF + 0x0000, ci=1 -> s=0x8000, co=0, ovf=1; sub 0x0005 - 0x0007 -> s=0xFFFE, co=0, ovf=0.
//   start pulsed again during RUN with different operands -> ignored; first result unchanged.
//     start held in DONE -> a new RUN begins immediately, with no IDLE cycle in between.
//   rst_n low for 1 cycle at the 2nd RUN cycle -> all outputs 0, no done, IDLE.
//     A following start completes normally.
//   Randomised: 1000 random a, b, ci, sub vs. a golden model, plus checks that done is 1 cycle wide and s is stable outside DONE edges.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 4-bit adder slice processes
// captured operands LSB-first, chaining a registered carry, then pulses done.
module add_seq_ctrl #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ovf
);

  localparam int unsigned NSLICE = W / 4;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     work;
  logic             carry;

  logic             capture_c;
  logic             step_c;
  logic             last_c;
  logic             busy_next;
  logic             done_next;
  logic [4:0]       slice_sum_c;
  logic [W-1:0]     result_c;
  logic             ovf_c;

  // Shared slice adder and the full result as it will look once this slice is written
  assign last_c      = (idx == IDX_W'(NSLICE - 1));
  assign slice_sum_c = 5'(a_q[4*idx +: 4]) + 5'(b_q[4*idx +: 4]) + 5'(carry);

  always_comb begin
    result_c = work;
    result_c[4*idx +: 4] = slice_sum_c[3:0];
  end

  assign ovf_c = (a_q[W-1] == b_q[W-1]) && (result_c[W-1] != a_q[W-1]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next = state;
    capture_c  = 1'b0;
    step_c     = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          capture_c  = 1'b1;
          busy_next  = 1'b1;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (last_c) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          busy_next  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          capture_c  = 1'b1;
          busy_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, slice accumulation and result/flag publication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      work  <= '0;
      carry <= 1'b0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (capture_c) begin
        a_q   <= a;
        b_q   <= sub ? ~b : b;
        carry <= sub ? 1'b1 : ci;
        idx   <= '0;
      end else if (step_c) begin
        work[4*idx +: 4] <= slice_sum_c[3:0];
        carry            <= slice_sum_c[4];
        if (last_c) begin
          idx <= '0;
          s   <= result_c;
          co  <= slice_sum_c[4];
          ovf <= ovf_c;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: directed vectors, start-ignore, back-to-back,
// mid-run reset and randomized operations against an integer-arithmetic reference.
module tb_add_seq_ctrl;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  add_seq_ctrl #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .ci   (ci),
    .busy (busy),
    .done (done),
    .s    (s),
    .co   (co),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain signed/unsigned integer arithmetic
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mci,
                                input logic msub, output logic [15:0] ms, output logic mco,
                                output logic movf);
    int ua, ub, sa, sb, full, sv;
    ua = int'(ma);
    ub = int'(mb);
    sa = $signed(ma);
    sb = $signed(mb);
    if (msub) begin
      full = ua - ub;
      mco  = (ua >= ub);
      sv   = sa - sb;
    end else begin
      full = ua + ub + int'(mci);
      mco  = (full >= 65536);
      sv   = sa + sb + int'(mci);
    end
    ms   = full[15:0];
    movf = (sv > 32767) || (sv < -32768);
  endfunction

  // Issue one operation, watch it through RUN, check result at the done cycle.
  // Returns at the negedge where done is visible (state DONE).
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                        input logic tsub, input logic [15:0] es, input logic eco,
                        input logic eovf, input bit mid_pulse, input string name);
    logic [15:0] s_prev;
    int n, nb;
    @(negedge clk);
    a = ta; b = tb_; ci = tci; sub = tsub; start = 1'b1;
    s_prev = s;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    n = 0; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      n_cmp++;
      if (s !== s_prev) begin
        n_err++;
        $display("FAIL %s s_stable: got %h want %h", name, s, s_prev);
      end
      if (mid_pulse && n == 1) begin
        start = 1'b1; a = ~ta; b = ~tb_; ci = ~tci;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    n_cmp++;
    if (n >= 20) begin
      n_err++;
      $display("FAIL %s timeout: no done after %0d cycles", name, n);
    end
    n_cmp++;
    if (nb != 4 || n != 4) begin
      n_err++;
      $display("FAIL %s busy_cycles: got busy=%0d latency=%0d want 4/4", name, nb, n);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_with_done: got %b want 0", name, busy);
    end
    n_cmp++;
    if (s !== es || co !== eco || ovf !== eovf) begin
      n_err++;
      $display("FAIL %s result: got s=%h co=%b ovf=%b want s=%h co=%b ovf=%b",
               name, s, co, ovf, es, eco, eovf);
    end
  endtask

  // After a done cycle with start low: done must drop and outputs hold
  task automatic check_done_width(input logic [15:0] es, input string name);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || s !== es) begin
      n_err++;
      $display("FAIL %s done_width: got done=%b busy=%b s=%h want 0/0/%h", name, done, busy, s, es);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h0 || co !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b s=%h co=%b ovf=%b want all 0",
               busy, done, s, co, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, "add_basic");
    check_done_width(16'h5555, "add_basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "add_ripple");
    check_done_width(16'h0000, "add_ripple");
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf");
    check_done_width(16'h8000, "add_ovf");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
    check_done_width(16'hFFFE, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
    check_done_width(16'h7FFF, "sub_ovf");
  endtask

  task automatic test_ignore_start();
    run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 1'b1, "ignore_start");
    check_done_width(16'h1010, "ignore_start");
  endtask

  task automatic test_back_to_back();
    int n;
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, "b2b_first");
    a = 16'h0100; b = 16'h0001; ci = 1'b0; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart: got busy=%b done=%b want 1/0", busy, done);
    end
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != 5) begin
      n_err++;
      $display("FAIL b2b_period: got %0d cycles done-to-done want 5", n);
    end
    n_cmp++;
    if (s !== 16'h00FF || co !== 1'b1 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: got s=%h co=%b ovf=%b want 00ff/1/0", s, co, ovf);
    end
    check_done_width(16'h00FF, "b2b_second");
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    a = 16'h2345; b = 16'h1111; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h0 || co !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset: got busy=%b done=%b s=%h co=%b ovf=%b want all 0",
               busy, done, s, co, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL midrun_idle: got %0d active cycles after reset want 0", seen);
    end
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, "after_reset");
    check_done_width(16'h0000, "after_reset");
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, es;
    logic rci, rsub, eco, eovf;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rci = 1'($urandom); rsub = 1'($urandom);
      if (i % 8 == 0) ra = 16'h7FFF ^ 16'($urandom_range(0, 3));
      model(ra, rb, rci, rsub, es, eco, eovf);
      run_op(ra, rb, rci, rsub, es, eco, eovf, (i % 5 == 0), "random");
      if (i % 3 != 0) check_done_width(es, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
